// File: rtl/kmap_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// kmap_sweep_ctrl_if : control, evaluator and result signals of the sweep
// sequencer.  Rev 1.0
// ============================================================================
interface kmap_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        f_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_err;
  logic        err_valid;

  // master: lab top level plus the evaluator it wires to a..d / f_in
  modport master (
    output start, abort, f_in,
    input  a, b, c, d, busy, done, pass, truth_table, mismatch_cnt,
           first_err, err_valid
  );

  // slave: the sweep sequencer itself
  modport slave (
    input  start, abort, f_in,
    output a, b, c, d, busy, done, pass, truth_table, mismatch_cnt,
           first_err, err_valid
  );
endinterface
`default_nettype wire

// File: rtl/kmap_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// kmap_sweep_ctrl : sweeps {A,B,C,D}=0..15 into the K-map evaluator, captures
// F into a truth table and grades it against EXPECTED.  Rev 1.0
// ============================================================================
module kmap_sweep_ctrl #(
  parameter int unsigned SETTLE   = 0,
  parameter logic [15:0] EXPECTED = 16'h6545
) (
  input  logic             clk,
  input  logic             rst_n,
  kmap_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LIM = 4'(SETTLE);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] tt_q, tt_d;
  logic        pass_q, pass_d;
  logic [4:0]  mcnt_q, mcnt_d;
  logic [3:0]  ferr_q, ferr_d;
  logic        errv_q, errv_d;

  logic [15:0] diff;
  logic [4:0]  diff_cnt;
  logic [3:0]  diff_first;

  // Downward scan so the last hit written is the lowest mismatching index.
  always_comb begin
    diff       = tt_q ^ EXPECTED;
    diff_cnt   = '0;
    diff_first = '0;
    for (int i = 15; i >= 0; i--) begin
      if (diff[i]) diff_first = 4'(i);
      diff_cnt = diff_cnt + 5'(diff[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    tt_d     = tt_q;
    pass_d   = pass_q;
    mcnt_d   = mcnt_q;
    ferr_d   = ferr_q;
    errv_d   = errv_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_SWEEP;
          idx_d    = '0;
          settle_d = '0;
          tt_d     = '0;
          pass_d   = 1'b0;
          mcnt_d   = '0;
          ferr_d   = '0;
          errv_d   = 1'b0;
        end
      end

      ST_SWEEP, ST_CHECK: begin
        if (bus.abort) begin
          state_d  = ST_IDLE;
          idx_d    = '0;
          settle_d = '0;
          tt_d     = '0;
          pass_d   = 1'b0;
          mcnt_d   = '0;
          ferr_d   = '0;
          errv_d   = 1'b0;
        end else if (state_q == ST_CHECK) begin
          state_d = ST_DONE;
          pass_d  = (diff_cnt == 5'd0);
          mcnt_d  = diff_cnt;
          ferr_d  = diff_first;
          errv_d  = (diff_cnt != 5'd0);
        end else if (settle_q == SETTLE_LIM) begin
          tt_d[idx_q] = bus.f_in;
          if (idx_q == 4'd15) begin
            state_d = ST_CHECK;
          end else begin
            idx_d    = idx_q + 4'd1;
            settle_d = '0;
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      tt_q     <= '0;
      pass_q   <= 1'b0;
      mcnt_q   <= '0;
      ferr_q   <= '0;
      errv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      tt_q     <= tt_d;
      pass_q   <= pass_d;
      mcnt_q   <= mcnt_d;
      ferr_q   <= ferr_d;
      errv_q   <= errv_d;
    end
  end

  // The applied vector is always the current index, so a..d come straight
  // from idx_q (0 after reset/abort, held at 1111 once the sweep completes).
  assign bus.a            = idx_q[3];
  assign bus.b            = idx_q[2];
  assign bus.c            = idx_q[1];
  assign bus.d            = idx_q[0];
  assign bus.busy         = (state_q == ST_SWEEP) || (state_q == ST_CHECK);
  assign bus.done         = (state_q == ST_DONE);
  assign bus.pass         = pass_q;
  assign bus.truth_table  = tt_q;
  assign bus.mismatch_cnt = mcnt_q;
  assign bus.first_err    = ferr_q;
  assign bus.err_valid    = errv_q;

endmodule
`default_nettype wire

// File: tb/tb_kmap_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// tb_kmap_sweep_ctrl : scoreboard bench for two sequencers (SETTLE=0 with a
// combinational or lagging evaluator, SETTLE=2 with a 2-stage one). Rev 1.0
// ============================================================================
module tb_kmap_sweep_ctrl;

  typedef struct {
    logic [15:0] tt;
    logic        pass;
    logic [4:0]  mcnt;
    logic [3:0]  ferr;
    logic        errv;
    int          dcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  kmap_sweep_ctrl_if if0 ();
  kmap_sweep_ctrl_if if2 ();

  kmap_sweep_ctrl #(.SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  kmap_sweep_ctrl #(.SETTLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sbq[2][$];

  logic        st[2];
  logic        ab[2];
  logic [15:0] tbl[2];
  logic        lag0;
  logic        p1_0, p2_0, p1_2, p2_2;

  logic [3:0]  abcd_s[2];
  logic [15:0] tt_s[2];
  logic [4:0]  mc_s[2];
  logic [3:0]  fe_s[2];
  logic        busy_s[2], done_s[2], pass_s[2], errv_s[2];

  assign if0.start = st[0];
  assign if0.abort = ab[0];
  assign if2.start = st[1];
  assign if2.abort = ab[1];

  assign abcd_s[0] = {if0.a, if0.b, if0.c, if0.d};
  assign abcd_s[1] = {if2.a, if2.b, if2.c, if2.d};
  assign tt_s[0] = if0.truth_table;   assign tt_s[1] = if2.truth_table;
  assign mc_s[0] = if0.mismatch_cnt;  assign mc_s[1] = if2.mismatch_cnt;
  assign fe_s[0] = if0.first_err;     assign fe_s[1] = if2.first_err;
  assign busy_s[0] = if0.busy;        assign busy_s[1] = if2.busy;
  assign done_s[0] = if0.done;        assign done_s[1] = if2.done;
  assign pass_s[0] = if0.pass;        assign pass_s[1] = if2.pass;
  assign errv_s[0] = if0.err_valid;   assign errv_s[1] = if2.err_valid;

  // Evaluator models: table lookup, optionally delayed by two register stages.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    p1_0 <= tbl[0][abcd_s[0]];
    p2_0 <= p1_0;
    p1_2 <= tbl[1][abcd_s[1]];
    p2_2 <= p1_2;
  end
  assign if0.f_in = lag0 ? p2_0 : tbl[0][abcd_s[0]];
  assign if2.f_in = p2_2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] golden();
    logic [15:0] t;
    logic [3:0]  x;
    for (int v = 0; v < 16; v++) begin
      x    = 4'(v);
      t[v] = (x[3] & x[2] & ~x[1] & x[0]) | (~x[2] & ~x[0]) | (x[1] & ~x[0]);
    end
    return t;
  endfunction

  // An evaluator two stages late shows vector i-2 at vector i (vector 0 before).
  function automatic logic [15:0] lagged(input logic [15:0] t);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = t[(i >= 2) ? i - 2 : 0];
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic [15:0] cap, input int dcyc);
    exp_t        e;
    logic [15:0] g;
    bit          found;
    g      = golden();
    found  = 1'b0;
    e.tt   = cap;
    e.mcnt = '0;
    e.ferr = '0;
    for (int i = 0; i < 16; i++) begin
      if (cap[i] != g[i]) begin
        e.mcnt = e.mcnt + 5'd1;
        if (!found) begin
          e.ferr = 4'(i);
          found  = 1'b1;
        end
      end
    end
    e.pass = (e.mcnt == 5'd0);
    e.errv = (e.mcnt != 5'd0);
    e.dcyc = dcyc;
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      if (done_s[s] === 1'b1) begin
        if (sbq[s].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done dut%0d: got done=1, expected no done (cycle %0d)", s, cyc);
        end else begin
          e = sbq[s].pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.dcyc));
          chk("truth_table", 32'(tt_s[s]), 32'(e.tt));
          chk("pass", 32'(pass_s[s]), 32'(e.pass));
          chk("mismatch_cnt", 32'(mc_s[s]), 32'(e.mcnt));
          chk("first_err", 32'(fe_s[s]), 32'(e.ferr));
          chk("err_valid", 32'(errv_s[s]), 32'(e.errv));
          chk("busy_at_done", 32'(busy_s[s]), 32'd0);
        end
      end
    end
  end

  task automatic chk_clear(input int s);
    chk("clr_busy", 32'(busy_s[s]), 32'd0);
    chk("clr_done", 32'(done_s[s]), 32'd0);
    chk("clr_abcd", 32'(abcd_s[s]), 32'd0);
    chk("clr_tt", 32'(tt_s[s]), 32'd0);
    chk("clr_pass", 32'(pass_s[s]), 32'd0);
    chk("clr_mcnt", 32'(mc_s[s]), 32'd0);
    chk("clr_ferr", 32'(fe_s[s]), 32'd0);
    chk("clr_errv", 32'(errv_s[s]), 32'd0);
  endtask

  // One accepted start on DUT s. kill_idx>=0 aborts (or resets) at that vector.
  task automatic sweep(input int s, input int kill_idx, input bit use_rst,
                       input bit poke, input bit ab_start);
    int          hold;
    int          e0c;
    int          t;
    logic [15:0] cap;
    hold = (s == 0) ? 1 : 3;
    @(negedge clk); #1;
    t = 0;
    while ((busy_s[s] !== 1'b0 || done_s[s] !== 1'b0) && t < 400) begin
      @(negedge clk); #1;
      t++;
    end
    chk("idle_wait_timeout", 32'(t >= 400), 32'd0);
    cap   = (s == 0 && lag0) ? lagged(tbl[0]) : tbl[s];
    st[s] = 1'b1;
    ab[s] = ab_start;
    @(posedge clk); #1;
    e0c = cyc;
    if (kill_idx < 0) sbq[s].push_back(mk_exp(cap, e0c + 16 * hold + 1));
    @(negedge clk);
    st[s] = 1'b0;
    ab[s] = 1'b0;
    chk("start_clr_tt", 32'(tt_s[s]), 32'd0);
    chk("start_clr_pass", 32'(pass_s[s]), 32'd0);
    chk("start_clr_mcnt", 32'(mc_s[s]), 32'd0);
    chk("start_clr_ferr", 32'(fe_s[s]), 32'd0);
    chk("start_clr_errv", 32'(errv_s[s]), 32'd0);
    for (int k = 0; k < 16 * hold; k++) begin
      if (k > 0) @(negedge clk);
      st[s] = 1'b0;
      chk("vector", 32'(abcd_s[s]), 32'(k / hold));
      chk("busy", 32'(busy_s[s]), 32'd1);
      if (kill_idx >= 0 && k == kill_idx * hold) begin
        if (use_rst) rst_n = 1'b0;
        else         ab[s] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        ab[s] = 1'b0;
        chk_clear(s);
        repeat (20) @(negedge clk);
        return;
      end
      if (poke && k == 3 * hold) st[s] = 1'b1;
    end
    for (t = 0; t < 20; t++) begin
      if (sbq[s].size() == 0) break;
      @(negedge clk); #1;
    end
    chk("done_timeout", 32'(sbq[s].size()), 32'd0);
    sbq[s].delete();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          s;
    int          mode;
    logic [15:0] g;
    g      = golden();
    tbl[0] = g;
    tbl[1] = g;
    lag0   = 1'b0;
    ab[0]  = 1'b0;
    ab[1]  = 1'b0;
    st[0]  = 1'b1;
    st[1]  = 1'b1;
    rst_n  = 1'b0;

    // Reset held with start asserted: nothing may start.
    repeat (3) begin
      @(negedge clk);
      chk_clear(0);
      chk_clear(1);
    end
    rst_n = 1'b1;
    st[0] = 1'b0;
    st[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy0", 32'(busy_s[0]), 32'd0);
      chk("post_rst_busy2", 32'(busy_s[1]), 32'd0);
    end

    // Golden runs, back to back.
    sweep(0, -1, 1'b0, 1'b0, 1'b0);
    sweep(0, -1, 1'b0, 1'b0, 1'b0);

    // abort while idle leaves the previous result untouched
    ab[0] = 1'b1;
    repeat (2) @(negedge clk);
    ab[0] = 1'b0;
    chk("idle_abort_pass", 32'(pass_s[0]), 32'd1);
    chk("idle_abort_tt", 32'(tt_s[0]), 32'(g));
    chk("idle_abort_busy", 32'(busy_s[0]), 32'd0);

    // Stuck-at evaluators.
    tbl[0] = 16'h0000;
    sweep(0, -1, 1'b0, 1'b0, 1'b0);
    tbl[0] = 16'hFFFF;
    sweep(0, -1, 1'b0, 1'b0, 1'b0);
    tbl[0] = g;

    // Registered evaluator: SETTLE=2 matches, SETTLE=0 reads stale data.
    sweep(1, -1, 1'b0, 1'b0, 1'b0);
    lag0  = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sweep(0, -1, 1'b0, 1'b0, 1'b0);
    lag0 = 1'b0;

    // Abort at idx 5, ignored start mid-sweep, reset at idx 9, start+abort.
    sweep(0, 5, 1'b0, 1'b0, 1'b0);
    sweep(0, -1, 1'b0, 1'b1, 1'b0);
    sweep(1, -1, 1'b0, 1'b1, 1'b0);
    sweep(0, 9, 1'b1, 1'b0, 1'b0);
    sweep(0, -1, 1'b0, 1'b0, 1'b1);
    sweep(1, 7, 1'b0, 1'b0, 1'b0);

    // Randomised evaluator faults on either sequencer.
    for (int r = 0; r < 12; r++) begin
      s    = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 4));
      case (mode)
        0:       tbl[s] = g;
        1:       tbl[s] = 16'h0000;
        2:       tbl[s] = 16'hFFFF;
        3:       tbl[s] = g ^ (16'h0001 << $urandom_range(0, 15));
        default: tbl[s] = 16'($urandom);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sweep(s, -1, 1'b0, ($urandom_range(0, 3) == 0), 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
